// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: control-unit, instruction-memory and decoded-field signals of the fetch unit.
interface instr_fetch_unit_if #(parameter int ADDR_W = 32);
   logic              updPC;
   logic [2:0]        brOp;
   logic              flag_neg;
   logic              flag_zero;
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_rdata;
   logic              imem_ack;
   logic [ADDR_W-1:0] pc;
   logic [5:0]        opcode;
   logic [4:0]        rs;
   logic [4:0]        rt;
   logic [4:0]        func;
   logic [15:0]       imm;
   logic [20:0]       br_off;
   logic              instr_valid;
   logic              br_taken;
   modport master (
      input  updPC, brOp, flag_neg, flag_zero, imem_rdata, imem_ack,
      output imem_req, imem_addr, pc, opcode, rs, rt, func, imm, br_off, instr_valid, br_taken
   );
   modport slave (
      output updPC, brOp, flag_neg, flag_zero, imem_rdata, imem_ack,
      input  imem_req, imem_addr, pc, opcode, rs, rt, func, imm, br_off, instr_valid, br_taken
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: program counter, branch resolution and instruction fetch over a req/ack port,
// holding the decoded fields stable between control-unit advance pulses.
module instr_fetch_unit #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic                clk,
   input logic                rst,
   instr_fetch_unit_if.master bus
);
   typedef enum logic [1:0] {S_RESET, S_FETCH, S_HOLD} state_t;
   localparam logic [ADDR_W-1:0] PC0 = {RESET_PC[ADDR_W-1:2], 2'b00};
   state_t            r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_instr;
   logic              r_req;
   logic              r_valid;
   logic              r_br;
   logic              r_upd_q;
   logic              w_edge;
   logic              w_taken;
   logic [ADDR_W-1:0] w_seq;
   logic [ADDR_W-1:0] w_tgt;
   assign w_edge  = bus.updPC & ~r_upd_q;
   assign w_seq   = r_pc + ADDR_W'(4);
   // word offset sign-extended and scaled to bytes; wraps modulo 2^ADDR_W
   assign w_tgt   = w_seq + {{(ADDR_W-23){r_instr[20]}}, r_instr[20:0], 2'b00};
   assign w_taken = (bus.brOp == 3'b000)
                  | (bus.brOp == 3'b001 &  bus.flag_neg)
                  | (bus.brOp == 3'b010 & ~bus.flag_neg & ~bus.flag_zero)
                  | (bus.brOp == 3'b011 &  bus.flag_zero);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_RESET;
         r_pc    <= PC0;
         r_addr  <= PC0;
         r_instr <= '0;
         r_req   <= 1'b0;
         r_valid <= 1'b0;
         r_br    <= 1'b0;
         r_upd_q <= 1'b0;
      end else begin
         r_upd_q <= bus.updPC;
         r_br    <= 1'b0;
         case (r_state)
            S_RESET: begin
               r_req   <= 1'b1;
               r_state <= S_FETCH;
            end
            S_FETCH: if (bus.imem_ack) begin
               r_instr <= bus.imem_rdata;
               r_pc    <= r_addr;
               r_valid <= 1'b1;
               r_req   <= 1'b0;
               r_state <= S_HOLD;
            end
            S_HOLD: if (w_edge) begin
               r_addr  <= w_taken ? w_tgt : w_seq;
               r_br    <= w_taken;
               r_valid <= 1'b0;
               r_req   <= 1'b1;
               r_state <= S_FETCH;
            end
            default: r_state <= S_RESET;
         endcase
      end
   end
   assign bus.imem_req    = r_req;
   assign bus.imem_addr   = r_addr;
   assign bus.pc          = r_pc;
   assign bus.opcode      = r_instr[31:26];
   assign bus.rs          = r_instr[25:21];
   assign bus.rt          = r_instr[20:16];
   assign bus.func        = r_instr[4:0];
   assign bus.imm         = r_instr[15:0];
   assign bus.br_off      = r_instr[20:0];
   assign bus.instr_valid = r_valid;
   assign bus.br_taken    = r_br;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed stimulus with a scoreboard; a negedge monitor checks every fetch
// request and every newly valid instruction against queued expectations.
module tb_instr_fetch_unit;
   typedef struct {logic [31:0] a; logic b;} fexp_t;
   typedef struct {logic [31:0] pc; logic [31:0] w;} iexp_t;
   logic clk = 1'b0;
   logic rst;
   int checks = 0;
   int errors = 0;
   fexp_t q_f[$];
   iexp_t q_i[$];
   logic pr = 1'b0, pv = 1'b0, pu = 1'b0;
   logic [31:0] pa = '0;
   instr_fetch_unit_if #(.ADDR_W(32)) bus();
   instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endfunction
   task automatic fetch(input int n, input int h, input logic [31:0] w);
      int t = 0;
      while (!bus.imem_req && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      for (int k = 0; k < n; k++) begin
         chk("req_held", 32'(bus.imem_req), 1);
         @(posedge clk); #1;
         if (k + 2 >= h) bus.updPC = 1'b0;
      end
      chk("req_held", 32'(bus.imem_req), 1);
      bus.imem_rdata = w;
      bus.imem_ack   = 1'b1;
      @(posedge clk); #1;
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 32'hDEADBEEF;
      chk("req_drop", 32'(bus.imem_req), 0);
      chk("valid_set", 32'(bus.instr_valid), 1);
   endtask
   task automatic step(input logic [2:0] op, input logic nf, input logic zf, input logic [31:0] a,
                       input logic b, input int n, input int h, input logic [31:0] w);
      q_f.push_back('{a, b});
      q_i.push_back('{a, w});
      bus.brOp = op;
      bus.flag_neg = nf;
      bus.flag_zero = zf;
      bus.updPC = 1'b1;
      @(posedge clk); #1;
      if (h <= 1) bus.updPC = 1'b0;
      bus.brOp = 3'b000;
      bus.flag_neg = ~nf;
      bus.flag_zero = ~zf;
      fetch(n, h, w);
      @(posedge clk); #1;
   endtask
   initial begin
      fexp_t f;
      iexp_t e;
      forever begin
         @(negedge clk);
         a_no_upd_in_fetch: assert (!(bus.updPC && !pu && bus.imem_req))
            else $error("FAIL upd_in_fetch: updPC edge while fetching");
         if (bus.imem_req && !pr) begin
            if (q_f.size() == 0) begin
               errors++;
               checks++;
               $display("FAIL fetch_unexpected: got request at %h expected none", bus.imem_addr);
            end else begin
               f = q_f.pop_front();
               chk("fetch_addr", bus.imem_addr, f.a);
               chk("br_taken", 32'(bus.br_taken), 32'(f.b));
            end
         end else chk("br_idle", 32'(bus.br_taken), 0);
         if (bus.imem_req && pr) chk("addr_stable", bus.imem_addr, pa);
         if (bus.instr_valid && !pv) begin
            if (q_i.size() == 0) begin
               errors++;
               checks++;
               $display("FAIL instr_unexpected: got pc %h expected none", bus.pc);
            end else begin
               e = q_i.pop_front();
               chk("pc", bus.pc, e.pc);
               chk("opcode", 32'(bus.opcode), 32'(e.w[31:26]));
               chk("rs", 32'(bus.rs), 32'(e.w[25:21]));
               chk("rt", 32'(bus.rt), 32'(e.w[20:16]));
               chk("func", 32'(bus.func), 32'(e.w[4:0]));
               chk("imm", 32'(bus.imm), 32'(e.w[15:0]));
               chk("br_off", 32'(bus.br_off), 32'(e.w[20:0]));
            end
         end
         pr = bus.imem_req;
         pv = bus.instr_valid;
         pa = bus.imem_addr;
         pu = bus.updPC;
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
   initial begin
      int t;
      rst = 1'b1;
      bus.updPC = 1'b0;
      bus.brOp = 3'b100;
      bus.flag_neg = 1'b0;
      bus.flag_zero = 1'b0;
      bus.imem_ack = 1'b0;
      bus.imem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", 32'(bus.imem_req), 0);
      chk("rst_addr", bus.imem_addr, 0);
      chk("rst_pc", bus.pc, 0);
      chk("rst_valid", 32'(bus.instr_valid), 0);
      chk("rst_br", 32'(bus.br_taken), 0);
      chk("rst_opcode", 32'(bus.opcode), 0);
      chk("rst_rs", 32'(bus.rs), 0);
      chk("rst_rt", 32'(bus.rt), 0);
      chk("rst_func", 32'(bus.func), 0);
      chk("rst_imm", 32'(bus.imm), 0);
      chk("rst_br_off", 32'(bus.br_off), 0);
      q_f.push_back('{32'h0, 1'b0});
      q_i.push_back('{32'h0, 32'h04221234});
      rst = 1'b0;
      fetch(0, 1, 32'h04221234);
      @(posedge clk); #1;
      step(3'b100, 0, 0, 32'h04, 0, 3, 1, 32'h2C000001);
      step(3'b100, 0, 0, 32'h08, 0, 3, 1, 32'h30000002);
      step(3'b100, 0, 0, 32'h0C, 0, 3, 1, 32'h0800000C);
      step(3'b000, 0, 0, 32'h40, 1, 0, 1, 32'h0C3FFFFE);
      step(3'b011, 0, 1, 32'h3C, 1, 1, 1, 32'h10000000);
      step(3'b000, 0, 0, 32'h40, 1, 2, 1, 32'h0C3FFFFE);
      step(3'b011, 0, 0, 32'h44, 0, 0, 1, 32'h14000004);
      step(3'b001, 1, 0, 32'h58, 1, 0, 1, 32'h18000004);
      step(3'b010, 1, 0, 32'h5C, 0, 0, 1, 32'h1C000004);
      step(3'b010, 0, 1, 32'h60, 0, 0, 1, 32'h20000004);
      step(3'b010, 0, 0, 32'h74, 1, 0, 1, 32'h24000004);
      step(3'b111, 1, 1, 32'h78, 0, 0, 1, 32'h28A5F00D);
      step(3'b001, 0, 1, 32'h7C, 0, 0, 1, 32'h2C000000);
      // abort a fetch at 0x80 with reset, then deliver its ack while reset is held
      q_f.push_back('{32'h80, 1'b0});
      bus.brOp = 3'b100;
      bus.updPC = 1'b1;
      @(posedge clk); #1;
      bus.updPC = 1'b0;
      repeat (2) begin
         chk("req_held", 32'(bus.imem_req), 1);
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      chk("abort_req", 32'(bus.imem_req), 0);
      chk("abort_addr", bus.imem_addr, 0);
      chk("abort_pc", bus.pc, 0);
      chk("abort_opcode", 32'(bus.opcode), 0);
      repeat (2) @(posedge clk);
      #1;
      bus.imem_rdata = 32'hFFFFFFFF;
      bus.imem_ack = 1'b1;
      @(posedge clk); #1;
      bus.imem_ack = 1'b0;
      chk("abort_hold_req", 32'(bus.imem_req), 0);
      chk("abort_hold_valid", 32'(bus.instr_valid), 0);
      q_f.push_back('{32'h0, 1'b0});
      q_i.push_back('{32'h0, 32'h0C3FFFFE});
      rst = 1'b0;
      fetch(2, 1, 32'h0C3FFFFE);
      @(posedge clk); #1;
      step(3'b000, 0, 0, 32'hFFFFFFFC, 1, 1, 1, 32'h3C000123);
      step(3'b100, 0, 0, 32'h00000000, 0, 3, 3, 32'h40000456);
      @(posedge clk); #1;
      chk("once_req", 32'(bus.imem_req), 0);
      bus.imem_rdata = 32'hFFFFFFFF;
      bus.imem_ack = 1'b1;
      @(posedge clk); #1;
      bus.imem_ack = 1'b0;
      @(posedge clk); #1;
      chk("stray_req", 32'(bus.imem_req), 0);
      chk("stray_valid", 32'(bus.instr_valid), 1);
      chk("stray_pc", bus.pc, 0);
      chk("stray_opcode", 32'(bus.opcode), 32'h10);
      chk("stray_imm", 32'(bus.imm), 32'h0456);
      t = 0;
      while ((q_f.size() != 0 || q_i.size() != 0) && t < 20) begin
         @(posedge clk);
         t++;
      end
      chk("fetch_q_drained", q_f.size(), 0);
      chk("instr_q_drained", q_i.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
